watch_display_driver: RTL and testbench
=======================================

Name: watch_display_driver

Overview:
- Reader for the digital watch's time outputs.
- Periodically snapshots binary hour/minute/second counts and converts them to BCD with a sequential shift-add-3 FSM.
- Time-multiplexes the six digits (HH MM SS) onto one active-low 7-segment bus.
- Sits between the watch core and the board's 6-digit common-anode display.

Parameters:
- SCAN_DIV, 17_000: clk cycles per digit dwell; legal range ≥ 8.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- second_count  input  6  binary seconds from watch core, 0..63 accepted
- minute_count  input  6  binary minutes, 0..63 accepted
- hour_count  input  5  binary hours, 0..31 accepted
- alarm_flash  input  1  alarm indicator from watch core
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low
- dp  output  1  decimal point, active-low
- an  output  6  digit anodes, active-low, one-hot-low when lit
- conv_busy  output  1  high while the BCD conversion FSM is not IDLE

Behaviour:
- One clock, clk. Reset is synchronous and active-high; all state is sampled on posedge clk.
- Reset values:
  - scan_cnt=0, digit_sel=0, state=IDLE.
  - All six digit registers=0.
  - seg=7'h7F, dp=1, an=6'h3F (display dark), conv_busy=0.
- Scan counter:
  - scan_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - tick is asserted in the cycle scan_cnt==SCAN_DIV-1.
  - On tick, digit_sel advances 0→1→…→5→0.
  - The tick that takes digit_sel from 5 to 0 also issues conv_start.
- Digit map:
  - digit_sel 0/1: seconds ones/tens, on an[0]/an[1].
  - digit_sel 2/3: minutes ones/tens, on an[2]/an[3].
  - digit_sel 4/5: hours ones/tens, on an[4]/an[5].
- Conversion FSM states: IDLE, SHIFT, DONE.
  - IDLE:
    - On conv_start, snapshot second_count, minute_count and {1'b0,hour_count} into three 6-bit binary shift registers.
    - Clear the three 8-bit BCD accumulators and set iteration counter=0, then go to SHIFT.
    - Without conv_start, stay in IDLE.
  - SHIFT, one iteration per cycle, per field:
    - Add 3 to any BCD nibble ≥5.
    - Shift {bcd,bin} left by 1.
    - After the 6th iteration (counter==5), go to DONE.
  - DONE:
    - Write all six BCD nibbles into the digit registers in this single cycle, then return to IDLE.
- Latency: conv_start in cycle t → digit registers hold the new values from cycle t+8. conv_busy is high during t+1..t+7.
- Inputs are sampled only at snapshot. Changes during SHIFT/DONE do not affect the frame in flight.
- conv_start arriving while not IDLE is ignored. This cannot occur when SCAN_DIV ≥ 8.
- Display outputs are registered and updated every cycle from the current digit_sel and digit registers (one-cycle lag):
  - an: bit digit_sel low, all other bits high.
  - seg: standard active-low 0–9 encoding (0 → 7'h40, 8 → 7'h00). Nibble values 10–15 decode to blank (7'h7F).
  - dp: low when digit_sel is 2 or 4 (HH.MM.SS separators) or alarm_flash=1; otherwise high.
- Range:
  - Inputs up to 63/63/31 convert exactly, e.g. 60 shows "60".
  - No clamping or validation; the watch core owns legality.
- Reset during SHIFT or DONE: the FSM returns to IDLE, digit registers clear to 0, and no partial result is written.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: when the hours tens digit register is 0, an[5] stays high (digit dark) during digit_sel==5; seg is still driven with the blank code.
- Undefined: the hours tens digit always displays, including "0".
- Minutes and seconds are never blanked in either build.

Test Plan:
- Reset held 3 cycles → an=6'h3F, seg=7'h7F, dp=1, conv_busy=0. After release with SCAN_DIV=8 and inputs 0, an[0]=0 and seg=7'h40 within 2 cycles.
- Inputs 23:59:45, wait one full frame (48 cycles at SCAN_DIV=8) → conv_busy high exactly 7 cycles. Digits then read sel0..5 = 5,4,9,5,3,2 (seg 7'h12,7'h19,7'h10,7'h12,7'h30,7'h24).
- Inputs 63:60 on minute/second, hour 31 → digits 0,6,3,6,1,3. Change inputs mid-SHIFT → the displayed frame is unchanged until the next conv_start.
- Hour 5, with LEADING_ZERO_BLANK_EN defined → an stays 6'h3F while digit_sel==5. Undefined → an=6'h1F with seg=7'h40.
- alarm_flash=1 → dp=0 on all six digits. alarm_flash=0 → dp=0 only when digit_sel is 2 or 4.
- Assert reset 3 cycles into SHIFT → next cycle state=IDLE, conv_busy=0, all digit registers 0, scan restarts at digit_sel=0.

Source files
------------

// File: rtl/watch_display_if.sv
// Bus between the watch core / board and the display driver: time inputs in, 7-segment scan out.
interface watch_display_if;
  logic [5:0] second_count;
  logic [5:0] minute_count;
  logic [4:0] hour_count;
  logic       alarm_flash;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       conv_busy;

  modport master (
    output second_count, minute_count, hour_count, alarm_flash,
    input  seg, dp, an, conv_busy
  );

  modport slave (
    input  second_count, minute_count, hour_count, alarm_flash,
    output seg, dp, an, conv_busy
  );
endinterface

// File: rtl/watch_display_driver.sv
// Snapshots watch time, converts it to BCD with a shift-add-3 FSM and scans six digits
// onto an active-low 7-segment bus. Optional macro: LEADING_ZERO_BLANK_EN (blank hours-tens zero).
module watch_display_driver #(
  parameter int unsigned SCAN_DIV = 17_000
) (
  input logic            clk,
  input logic            reset,
  watch_display_if.slave bus
);
  localparam int unsigned CNT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BIN_W  = 6;
  localparam int unsigned BCD_W  = 8;
  localparam int unsigned SEL_W  = 3;
  localparam int unsigned NDIG   = 6;
  localparam int unsigned ITER_W = 3;
  localparam int unsigned SEG_W  = 7;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  logic [CNT_W-1:0]  scan_cnt;
  logic [SEL_W-1:0]  digit_sel;
  logic              tick;
  logic              conv_start;
  state_t            state;
  logic [ITER_W-1:0] iter;
  logic [BIN_W-1:0]  bin_s, bin_m, bin_h;
  logic [BCD_W-1:0]  bcd_s, bcd_m, bcd_h;
  logic [3:0]        digit [NDIG];
  logic [3:0]        cur_digit;
  logic [SEG_W-1:0]  seg_q;
  logic              dp_q;
  logic [NDIG-1:0]   an_q;
  logic              busy_q;

  assign tick       = (scan_cnt == CNT_W'(SCAN_DIV - 1));
  assign conv_start = tick && (digit_sel == SEL_W'(NDIG - 1));

  assign bus.seg       = seg_q;
  assign bus.dp        = dp_q;
  assign bus.an        = an_q;
  assign bus.conv_busy = busy_q;

  // Add 3 to every BCD nibble that would overflow past 9 on the next shift.
  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] b);
    logic [BCD_W-1:0] r;
    r = b;
    if (b[3:0] >= 4'd5) r[3:0] = b[3:0] + 4'd3;
    if (b[7:4] >= 4'd5) r[7:4] = b[7:4] + 4'd3;
    return r;
  endfunction

  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] d);
    logic [SEG_W-1:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    cur_digit = 4'd0;
    case (digit_sel)
      3'd0:    cur_digit = digit[0];
      3'd1:    cur_digit = digit[1];
      3'd2:    cur_digit = digit[2];
      3'd3:    cur_digit = digit[3];
      3'd4:    cur_digit = digit[4];
      3'd5:    cur_digit = digit[5];
      default: cur_digit = 4'd0;
    endcase
  end

  // Digit dwell counter and digit selector.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt  <= '0;
      digit_sel <= '0;
    end else begin
      scan_cnt <= tick ? '0 : scan_cnt + CNT_W'(1);
      if (tick) digit_sel <= (digit_sel == SEL_W'(NDIG - 1)) ? '0 : digit_sel + SEL_W'(1);
    end
  end

  // Binary-to-BCD conversion FSM; digit registers only change in DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      iter   <= '0;
      busy_q <= 1'b0;
      bin_s  <= '0;
      bin_m  <= '0;
      bin_h  <= '0;
      bcd_s  <= '0;
      bcd_m  <= '0;
      bcd_h  <= '0;
      for (int i = 0; i < int'(NDIG); i++) digit[i] <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (conv_start) begin
            bin_s  <= bus.second_count;
            bin_m  <= bus.minute_count;
            bin_h  <= {1'b0, bus.hour_count};
            bcd_s  <= '0;
            bcd_m  <= '0;
            bcd_h  <= '0;
            iter   <= '0;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd_s, bin_s} <= {add3(bcd_s), bin_s} << 1;
          {bcd_m, bin_m} <= {add3(bcd_m), bin_m} << 1;
          {bcd_h, bin_h} <= {add3(bcd_h), bin_h} << 1;
          iter <= iter + ITER_W'(1);
          if (iter == ITER_W'(BIN_W - 1)) state <= DONE;
        end
        DONE: begin
          digit[0] <= bcd_s[3:0];
          digit[1] <= bcd_s[7:4];
          digit[2] <= bcd_m[3:0];
          digit[3] <= bcd_m[7:4];
          digit[4] <= bcd_h[3:0];
          digit[5] <= bcd_h[7:4];
          busy_q   <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Registered display outputs, one cycle behind digit_sel.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
      an_q  <= 6'h3F;
    end else begin
      seg_q <= seg_decode(cur_digit);
      an_q  <= ~(NDIG'(1) << digit_sel);
      dp_q  <= ~((digit_sel == SEL_W'(2)) || (digit_sel == SEL_W'(4)) || bus.alarm_flash);
`ifdef LEADING_ZERO_BLANK_EN
      if ((digit_sel == SEL_W'(NDIG - 1)) && (digit[5] == 4'd0)) begin
        seg_q <= 7'h7F;
        an_q  <= 6'h3F;
      end
`endif
    end
  end

endmodule

// File: tb/tb_watch_display_driver.sv
// Directed self-checking bench for watch_display_driver at SCAN_DIV=8 (48-cycle frame).
module tb_watch_display_driver;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  watch_display_if bus ();

  watch_display_driver #(.SCAN_DIV(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_an(input logic [5:0] want, output logic found);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.an === want) found = 1'b1;
    end
  endtask

  // Advance at least one cycle, then wait for the digit's anode and check its segments/dp.
  task automatic check_digit(input string tag, input int sel, input logic [6:0] exp_seg,
                             input logic exp_dp);
    logic [5:0] want;
    logic       found;
    want = ~(6'd1 << sel);
    wait_an(want, found);
    check({tag, "_an_found"}, 8'(found), 8'd1);
    if (found) begin
      check({tag, "_seg"}, 8'(bus.seg), 8'(exp_seg));
      check({tag, "_dp"},  8'(bus.dp),  8'(exp_dp));
    end
  endtask

  task automatic wait_busy(input logic level, input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.conv_busy === level) found = 1'b1;
    end
    check(tag, 8'(found), 8'd1);
  endtask

  task automatic set_time(input int h, input int m, input int s);
    bus.hour_count   = 5'(h);
    bus.minute_count = 6'(m);
    bus.second_count = 6'(s);
  endtask

  initial begin
    int busy_cycles;
    logic found;

    reset = 1'b1;
    bus.alarm_flash = 1'b0;
    set_time(0, 0, 0);
    step(3);
    check("rst_an",   8'(bus.an),        8'h3F);
    check("rst_seg",  8'(bus.seg),       8'h7F);
    check("rst_dp",   8'(bus.dp),        8'h01);
    check("rst_busy", 8'(bus.conv_busy), 8'h00);

    reset = 1'b0;
    step(1);
    check("rel_an",  8'(bus.an),  8'h3E);
    check("rel_seg", 8'(bus.seg), 8'h40);

    // 23:59:45; the first conversion of the frame lands inside this window.
    set_time(23, 59, 45);
    busy_cycles = 0;
    for (int i = 0; i < 56; i++) begin
      @(negedge clk);
      if (bus.conv_busy === 1'b1) busy_cycles++;
    end
    check("busy_len", 8'(busy_cycles), 8'd7);
    check_digit("t1_d0", 0, 7'h12, 1'b1);
    check_digit("t1_d1", 1, 7'h19, 1'b1);
    check_digit("t1_d2", 2, 7'h10, 1'b0);
    check_digit("t1_d3", 3, 7'h12, 1'b1);
    check_digit("t1_d4", 4, 7'h30, 1'b0);
    check_digit("t1_d5", 5, 7'h24, 1'b1);

    // Out-of-range-looking values convert exactly; mid-SHIFT input changes are ignored.
    set_time(31, 63, 60);
    wait_busy(1'b1, "t2_busy_hi");
    wait_busy(1'b0, "t2_busy_lo");
    wait_busy(1'b1, "t3_busy_hi");
    set_time(12, 34, 56);
    wait_busy(1'b0, "t3_busy_lo");
    check_digit("t3_d0", 0, 7'h40, 1'b1);
    check_digit("t3_d1", 1, 7'h02, 1'b1);
    check_digit("t3_d2", 2, 7'h30, 1'b0);
    check_digit("t3_d3", 3, 7'h02, 1'b1);
    check_digit("t3_d4", 4, 7'h79, 1'b0);
    check_digit("t3_d5", 5, 7'h30, 1'b1);

    // Next frame picks up 12:34:56; also exercise alarm_flash on every digit.
    wait_busy(1'b1, "t4_busy_hi");
    wait_busy(1'b0, "t4_busy_lo");
    bus.alarm_flash = 1'b1;
    check_digit("al_d0", 0, 7'h02, 1'b0);
    check_digit("al_d1", 1, 7'h12, 1'b0);
    check_digit("al_d2", 2, 7'h19, 1'b0);
    check_digit("al_d3", 3, 7'h30, 1'b0);
    check_digit("al_d4", 4, 7'h24, 1'b0);
    check_digit("al_d5", 5, 7'h79, 1'b0);
    bus.alarm_flash = 1'b0;

    // Single-digit hour: hours-tens is zero.
    set_time(5, 34, 56);
    wait_busy(1'b1, "t5_busy_hi");
    wait_busy(1'b0, "t5_busy_lo");
    check_digit("t5_d4", 4, 7'h12, 1'b0);
`ifdef LEADING_ZERO_BLANK_EN
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.an !== 6'h2F) found = 1'b1;
    end
    check("lzb_left_d4", 8'(found), 8'd1);
    check("lzb_an",  8'(bus.an),  8'h3F);
    check("lzb_seg", 8'(bus.seg), 8'h7F);
    step(4);
    check("lzb_an_hold", 8'(bus.an), 8'h3F);
`else
    check_digit("t5_d5", 5, 7'h40, 1'b1);
`endif

    // Reset three cycles into SHIFT: no partial result, display and scan restart.
    set_time(12, 34, 56);
    wait_busy(1'b1, "t6_busy_hi");
    step(2);
    reset = 1'b1;
    step(1);
    check("mid_rst_busy", 8'(bus.conv_busy), 8'h00);
    check("mid_rst_an",   8'(bus.an),        8'h3F);
    check("mid_rst_seg",  8'(bus.seg),       8'h7F);
    step(2);
    reset = 1'b0;
    step(1);
    check("post_rst_an",  8'(bus.an),  8'h3E);
    check("post_rst_seg", 8'(bus.seg), 8'h40);
    check("post_rst_busy", 8'(bus.conv_busy), 8'h00);
    check_digit("pr_d1", 1, 7'h40, 1'b1);
    check_digit("pr_d2", 2, 7'h40, 1'b0);
    check_digit("pr_d3", 3, 7'h40, 1'b1);
    check_digit("pr_d4", 4, 7'h40, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
